// File: rtl/next_pc_unit_if.sv
// next_pc_unit_if: signal bundle between control/ALU-compare logic and the
// next-PC unit. The master drives next-PC controls; the slave (the PC unit)
// returns the registered fetch address, link and trap status.
// Optional macro NEXT_PC_REDIRECT_COUNT_EN adds redirect_count_o.
interface next_pc_unit_if #(
    parameter int NBITS     = 32,
    parameter int IMM_WIDTH = 21
) ();
    logic                 stall_i;
    logic [1:0]           mode_i;
    logic                 branch_taken_i;
    logic [NBITS-1:0]     rs1_i;
    logic [IMM_WIDTH-1:0] imm_i;
    logic                 trap_ack_i;
    logic [NBITS-1:0]     pc_o;
    logic                 fetch_valid_o;
    logic [NBITS-1:0]     link_o;
    logic                 redirect_o;
    logic                 misalign_o;
    logic [NBITS-1:0]     bad_addr_o;
`ifdef NEXT_PC_REDIRECT_COUNT_EN
    logic [NBITS-1:0]     redirect_count_o;
`endif

`ifdef NEXT_PC_REDIRECT_COUNT_EN
    modport master (
        output stall_i, mode_i, branch_taken_i, rs1_i, imm_i, trap_ack_i,
        input  pc_o, fetch_valid_o, link_o, redirect_o, misalign_o, bad_addr_o,
        input  redirect_count_o
    );
    modport slave (
        input  stall_i, mode_i, branch_taken_i, rs1_i, imm_i, trap_ack_i,
        output pc_o, fetch_valid_o, link_o, redirect_o, misalign_o, bad_addr_o,
        output redirect_count_o
    );
`else
    modport master (
        output stall_i, mode_i, branch_taken_i, rs1_i, imm_i, trap_ack_i,
        input  pc_o, fetch_valid_o, link_o, redirect_o, misalign_o, bad_addr_o
    );
    modport slave (
        input  stall_i, mode_i, branch_taken_i, rs1_i, imm_i, trap_ack_i,
        output pc_o, fetch_valid_o, link_o, redirect_o, misalign_o, bad_addr_o
    );
`endif
endinterface

// File: rtl/next_pc_unit.sv
// next_pc_unit: registered program counter and next-PC generator.
// Computes SEQ/BRANCH/JAL/JALR targets, honours stall, captures the link
// address, and traps misaligned targets through a BOOT/RUN/TRAP FSM.
// Optional macro NEXT_PC_REDIRECT_COUNT_EN adds a wrapping redirect counter.

// Property checker for the PC unit; holds no state of its own.
module next_pc_unit_chk #(
    parameter int               NBITS       = 32,
    parameter logic [NBITS-1:0] TRAP_VECTOR = NBITS'(32'h0040_0100)
) (
    input logic             clk,
    input logic             reset,
    input logic [NBITS-1:0] pc,
    input logic             fetch_valid,
    input logic             misalign
);
    // The fetch address can never leave word alignment.
    a_pc_aligned: assert property (@(posedge clk) disable iff (!reset)
        pc[1:0] == 2'b00);

    // A pending trap never coincides with a valid fetch.
    a_trap_no_fetch: assert property (@(posedge clk) disable iff (!reset)
        !(misalign && fetch_valid));

    // While a trap is pending the PC sits on the trap vector.
    a_trap_pc: assert property (@(posedge clk) disable iff (!reset)
        misalign |-> (pc == TRAP_VECTOR));
endmodule

module next_pc_unit #(
    parameter int               NBITS       = 32,
    parameter int               IMM_WIDTH   = 21,
    parameter logic [NBITS-1:0] RESET_PC    = NBITS'(32'h0040_0000),
    parameter logic [NBITS-1:0] TRAP_VECTOR = NBITS'(32'h0040_0100)
) (
    input logic             clk,
    input logic             reset,
    next_pc_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_SEQ    = 2'b00,
        MODE_BRANCH = 2'b01,
        MODE_JAL    = 2'b10,
        MODE_JALR   = 2'b11
    } mode_e;

    localparam logic [NBITS-1:0] PC_STEP   = NBITS'(32'd4);
    localparam logic [NBITS-1:0] JALR_MASK = {{(NBITS-1){1'b1}}, 1'b0};

    // Two's-complement widening of the immediate to datapath width.
    function automatic logic [NBITS-1:0] sign_ext(input logic [IMM_WIDTH-1:0] imm);
        return {{(NBITS-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    endfunction

    state_e           state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [NBITS-1:0] link_q, link_d;
    logic [NBITS-1:0] bad_addr_q, bad_addr_d;
    logic             redirect_q, redirect_d;
    logic             misalign_q, misalign_d;
    logic             fetch_valid_q, fetch_valid_d;
`ifdef NEXT_PC_REDIRECT_COUNT_EN
    logic [NBITS-1:0] redirect_count_q, redirect_count_d;
`endif

    logic [NBITS-1:0] simm_s;
    logic [NBITS-1:0] seq_pc_s;
    logic [NBITS-1:0] target_s;
    logic             nonseq_s;
    logic             is_jump_s;

    // Target selection: every mode's candidate address, wrapping arithmetic.
    always_comb begin
        simm_s    = sign_ext(bus.imm_i);
        seq_pc_s  = pc_q + PC_STEP;
        target_s  = seq_pc_s;
        nonseq_s  = 1'b0;
        is_jump_s = 1'b0;
        case (bus.mode_i)
            MODE_SEQ: begin
                target_s = seq_pc_s;
            end
            MODE_BRANCH: begin
                if (bus.branch_taken_i) begin
                    target_s = pc_q + simm_s;
                    nonseq_s = 1'b1;
                end else begin
                    target_s = seq_pc_s;
                end
            end
            MODE_JAL: begin
                target_s  = pc_q + simm_s;
                nonseq_s  = 1'b1;
                is_jump_s = 1'b1;
            end
            MODE_JALR: begin
                target_s  = (bus.rs1_i + simm_s) & JALR_MASK;
                nonseq_s  = 1'b1;
                is_jump_s = 1'b1;
            end
            default: begin
                target_s = seq_pc_s;
            end
        endcase
    end

    // Next-state logic for the FSM, PC, link and trap status.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        link_d     = link_q;
        bad_addr_d = bad_addr_q;
        redirect_d = 1'b0;
        misalign_d = misalign_q;
        case (state_q)
            ST_BOOT: begin
                // Inputs are ignored while the fetch path comes up.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.stall_i) begin
                    state_d = ST_RUN;
                end else if (target_s[1:0] != 2'b00) begin
                    // Misaligned target: vector to the handler, keep the link.
                    pc_d       = TRAP_VECTOR;
                    bad_addr_d = target_s;
                    misalign_d = 1'b1;
                    redirect_d = 1'b1;
                    state_d    = ST_TRAP;
                end else begin
                    pc_d       = target_s;
                    redirect_d = nonseq_s;
                    if (is_jump_s) begin
                        link_d = seq_pc_s;
                    end else begin
                        link_d = link_q;
                    end
                end
            end
            ST_TRAP: begin
                // Only the handler acknowledge is observed here.
                if (bus.trap_ack_i) begin
                    misalign_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_TRAP;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a clean boot.
                state_d    = ST_BOOT;
                pc_d       = RESET_PC;
                misalign_d = 1'b0;
            end
        endcase
        fetch_valid_d = (state_d == ST_RUN);
    end

`ifdef NEXT_PC_REDIRECT_COUNT_EN
    // Redirect counter advances with every redirect pulse, traps included.
    always_comb begin
        if (redirect_d) begin
            redirect_count_d = redirect_count_q + NBITS'(32'd1);
        end else begin
            redirect_count_d = redirect_count_q;
        end
    end
`endif

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_BOOT;
            pc_q             <= RESET_PC;
            link_q           <= '0;
            bad_addr_q       <= '0;
            redirect_q       <= 1'b0;
            misalign_q       <= 1'b0;
            fetch_valid_q    <= 1'b0;
`ifdef NEXT_PC_REDIRECT_COUNT_EN
            redirect_count_q <= '0;
`endif
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            link_q           <= link_d;
            bad_addr_q       <= bad_addr_d;
            redirect_q       <= redirect_d;
            misalign_q       <= misalign_d;
            fetch_valid_q    <= fetch_valid_d;
`ifdef NEXT_PC_REDIRECT_COUNT_EN
            redirect_count_q <= redirect_count_d;
`endif
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.fetch_valid_o = fetch_valid_q;
    assign bus.link_o        = link_q;
    assign bus.redirect_o    = redirect_q;
    assign bus.misalign_o    = misalign_q;
    assign bus.bad_addr_o    = bad_addr_q;
`ifdef NEXT_PC_REDIRECT_COUNT_EN
    assign bus.redirect_count_o = redirect_count_q;
`endif

    next_pc_unit_chk #(
        .NBITS       (NBITS),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_chk (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc_q),
        .fetch_valid (fetch_valid_q),
        .misalign    (misalign_q)
    );
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: scoreboard bench for next_pc_unit. A reference model
// predicts the registered outputs for each driven cycle; predictions are
// queued at drive time and compared after the clock edge.
module tb_next_pc_unit;
    localparam logic [31:0] RESET_PC    = 32'h0040_0000;
    localparam logic [31:0] TRAP_VECTOR = 32'h0040_0100;

    logic clk;
    logic reset;

    next_pc_unit_if #(.NBITS(32), .IMM_WIDTH(21)) bus ();

    next_pc_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic [31:0] link;
        logic        redir;
        logic        mis;
        logic [31:0] bad;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int step_no  = 0;

    // reference model state: 0 BOOT, 1 RUN, 2 TRAP
    int          m_state;
    logic [31:0] m_pc, m_link, m_bad, m_cnt;
    logic        m_fv, m_redir, m_mis;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d got=%h expected=%h", tag, step_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = RESET_PC;
        m_link  = 32'h0;
        m_bad   = 32'h0;
        m_cnt   = 32'h0;
        m_fv    = 1'b0;
        m_redir = 1'b0;
        m_mis   = 1'b0;
    endtask

    task automatic model_next(input logic stall, input logic [1:0] mode, input logic taken,
                              input logic [31:0] rs1, input logic [20:0] imm, input logic ack);
        logic [31:0] simm, tgt;
        simm    = 32'($signed(imm));
        m_redir = 1'b0;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            case (mode)
                2'd0: tgt = m_pc + 32'd4;
                2'd1: tgt = taken ? (m_pc + simm) : (m_pc + 32'd4);
                2'd2: tgt = m_pc + simm;
                default: tgt = (rs1 + simm) & 32'hFFFF_FFFE;
            endcase
            if (!stall) begin
                if (tgt[1:0] != 2'b00) begin
                    m_bad   = tgt;
                    m_pc    = TRAP_VECTOR;
                    m_mis   = 1'b1;
                    m_redir = 1'b1;
                    m_state = 2;
                end else begin
                    if (mode >= 2'd2) m_link = m_pc + 32'd4;
                    m_redir = (mode != 2'd0) && (mode != 2'd1 || taken);
                    m_pc    = tgt;
                end
            end
        end else begin
            if (ack) begin
                m_mis   = 1'b0;
                m_state = 1;
            end
        end
        m_fv = (m_state == 1);
        if (m_redir) m_cnt = m_cnt + 32'd1;
    endtask

    task automatic step(input logic stall, input logic [1:0] mode, input logic taken,
                        input logic [31:0] rs1, input logic [20:0] imm, input logic ack);
        exp_t e;
        @(negedge clk);
        bus.stall_i        = stall;
        bus.mode_i         = mode;
        bus.branch_taken_i = taken;
        bus.rs1_i          = rs1;
        bus.imm_i          = imm;
        bus.trap_ack_i     = ack;
        model_next(stall, mode, taken, rs1, imm, ack);
        e.pc = m_pc; e.fv = m_fv; e.link = m_link; e.redir = m_redir;
        e.mis = m_mis; e.bad = m_bad; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        e = exp_q.pop_front();
        check_val("pc", bus.pc_o, e.pc);
        check_val("fetch_valid", 32'(bus.fetch_valid_o), 32'(e.fv));
        check_val("link", bus.link_o, e.link);
        check_val("redirect", 32'(bus.redirect_o), 32'(e.redir));
        check_val("misalign", 32'(bus.misalign_o), 32'(e.mis));
        check_val("bad_addr", bus.bad_addr_o, e.bad);
`ifdef NEXT_PC_REDIRECT_COUNT_EN
        check_val("redirect_count", bus.redirect_count_o, e.cnt);
`endif
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_pc"}, bus.pc_o, RESET_PC);
        check_val({tag, "_fv"}, 32'(bus.fetch_valid_o), 32'd0);
        check_val({tag, "_link"}, bus.link_o, 32'd0);
        check_val({tag, "_redir"}, 32'(bus.redirect_o), 32'd0);
        check_val({tag, "_mis"}, 32'(bus.misalign_o), 32'd0);
        check_val({tag, "_bad"}, bus.bad_addr_o, 32'd0);
`ifdef NEXT_PC_REDIRECT_COUNT_EN
        check_val({tag, "_cnt"}, bus.redirect_count_o, 32'd0);
`endif
    endtask

    // Assert reset between edges and check that outputs clear immediately.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    localparam logic [1:0] SEQ = 2'd0, BR = 2'd1, JAL = 2'd2, JALR = 2'd3;

    initial begin
        logic        r_stall, r_taken, r_ack;
        logic [1:0]  r_mode;
        logic [31:0] r_rs1;
        logic [20:0] r_imm;

        reset = 1'b0;
        bus.stall_i = 1'b0; bus.mode_i = 2'd0; bus.branch_taken_i = 1'b0;
        bus.rs1_i = 32'd0; bus.imm_i = 21'd0; bus.trap_ack_i = 1'b0;
        model_reset();
        #12;
        check_reset_values("rst_init");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // boot cycle ignores a misaligned JAL, then two sequential steps
        step(1'b0, JAL, 1'b0, 32'd0, 21'h000003, 1'b0);
        check_val("tp_boot_pc", bus.pc_o, 32'h0040_0000);
        step(1'b0, SEQ, 1'b0, 32'd0, 21'd0, 1'b0);
        step(1'b0, SEQ, 1'b0, 32'd0, 21'd0, 1'b1);
        check_val("tp_seq_pc", bus.pc_o, 32'h0040_0008);

        // taken and not-taken branch at 0x00400010
        step(1'b0, SEQ, 1'b0, 32'd0, 21'd0, 1'b0);
        step(1'b0, SEQ, 1'b0, 32'd0, 21'd0, 1'b0);
        step(1'b0, BR, 1'b1, 32'd0, 21'h1FFFF8, 1'b0);
        check_val("tp_br_taken_pc", bus.pc_o, 32'h0040_0008);
        check_val("tp_br_taken_redir", 32'(bus.redirect_o), 32'd1);
        step(1'b0, SEQ, 1'b0, 32'd0, 21'd0, 1'b0);
        step(1'b0, SEQ, 1'b0, 32'd0, 21'd0, 1'b0);
        step(1'b0, BR, 1'b0, 32'd0, 21'h1FFFF8, 1'b0);
        check_val("tp_br_nt_pc", bus.pc_o, 32'h0040_0014);

        // JALR aligned, jump back, JALR misaligned into TRAP
        step(1'b0, SEQ, 1'b0, 32'd0, 21'd0, 1'b0);
        step(1'b0, SEQ, 1'b0, 32'd0, 21'd0, 1'b0);
        step(1'b0, SEQ, 1'b0, 32'd0, 21'd0, 1'b0);
        step(1'b0, JALR, 1'b0, 32'h0040_0101, 21'd3, 1'b0);
        check_val("tp_jalr_pc", bus.pc_o, 32'h0040_0104);
        check_val("tp_jalr_link", bus.link_o, 32'h0040_0024);
        step(1'b0, JAL, 1'b0, 32'd0, 21'h1FFF1C, 1'b0);
        step(1'b0, JALR, 1'b0, 32'h0040_0101, 21'd1, 1'b0);
        check_val("tp_trap_pc", bus.pc_o, 32'h0040_0100);
        check_val("tp_trap_bad", bus.bad_addr_o, 32'h0040_0102);
        check_val("tp_trap_mis", 32'(bus.misalign_o), 32'd1);

        // TRAP ignores stall/mode; ack returns to RUN at the vector
        for (int i = 0; i < 4; i++) step(1'b1, JAL, 1'b0, 32'd0, 21'h000100, 1'b0);
        step(1'b0, JAL, 1'b0, 32'd0, 21'h000100, 1'b1);
        check_val("tp_ack_pc", bus.pc_o, 32'h0040_0100);
        check_val("tp_ack_fv", 32'(bus.fetch_valid_o), 32'd1);

        // stalled JAL at 0x00400040
        step(1'b0, JAL, 1'b0, 32'd0, 21'h1FFF40, 1'b0);
        step(1'b1, JAL, 1'b0, 32'd0, 21'h000100, 1'b0);
        step(1'b1, JAL, 1'b0, 32'd0, 21'h000100, 1'b1);
        step(1'b0, JAL, 1'b0, 32'd0, 21'h000100, 1'b0);
        check_val("tp_jal_pc", bus.pc_o, 32'h0040_0140);
        check_val("tp_jal_link", bus.link_o, 32'h0040_0044);

        // wrap-around from 0xFFFFFFFC
        step(1'b0, JALR, 1'b0, 32'hFFFF_FFF0, 21'h00000C, 1'b0);
        step(1'b0, SEQ, 1'b0, 32'd0, 21'd0, 1'b0);
        check_val("tp_wrap_pc", bus.pc_o, 32'h0000_0000);
        check_val("tp_wrap_mis", 32'(bus.misalign_o), 32'd0);

        // constrained-random traffic
        for (int i = 0; i < 150; i++) begin
            r_mode  = 2'($urandom_range(0, 3));
            r_stall = ($urandom_range(0, 3) == 0);
            r_taken = 1'($urandom_range(0, 1));
            r_ack   = ($urandom_range(0, 2) == 0);
            r_rs1   = $urandom;
            r_imm   = 21'($urandom) & 21'h1FFFFC;
            if ($urandom_range(0, 7) == 0) r_imm[1:0] = 2'($urandom_range(1, 3));
            step(r_stall, r_mode, r_taken, r_rs1, r_imm, r_ack);
        end

        // reset during a stall
        step(1'b1, JAL, 1'b0, 32'd0, 21'h000100, 1'b0);
        do_reset("rst_stall");

        // two taken branches and one trap, then reset mid-TRAP
        step(1'b0, SEQ, 1'b0, 32'd0, 21'd0, 1'b0);
        step(1'b0, BR, 1'b1, 32'd0, 21'd8, 1'b0);
        step(1'b0, BR, 1'b1, 32'd0, 21'd8, 1'b0);
        step(1'b0, JAL, 1'b0, 32'd0, 21'd2, 1'b0);
        check_val("tp_cnt_bad", bus.bad_addr_o, 32'h0040_0012);
`ifdef NEXT_PC_REDIRECT_COUNT_EN
        check_val("tp_cnt_three", bus.redirect_count_o, 32'd3);
`endif
        step(1'b1, SEQ, 1'b0, 32'd0, 21'd0, 1'b0);
        do_reset("rst_trap");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
